// File: rtl/equiv_pkg.sv
// Shared types and default widths for the equivalence response checker.
// Defaults match the port widths of the combinational netlists under test.
package equiv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefInW = 20;
    localparam int unsigned DefOutW = 10;
    // x^10 + x^3 + 1
    localparam logic [DefOutW-1:0] DefMisrPoly = 10'h009;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shift left, fold the MSB back through POLY,
// and XOR in the parallel input word on every enabled cycle.
module misr_reg
    import equiv_pkg::*;
#(
    parameter int unsigned          WIDTH = DefOutW,
    parameter logic [WIDTH-1:0]     POLY  = WIDTH'(DefMisrPoly)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/equiv_response_checker.sv
// Multi-vector equivalence checker between an original and an optimized netlist:
// counts mismatches, latches the first failing vector and signs the optimized responses.
module equiv_response_checker
    import equiv_pkg::*;
#(
    parameter int unsigned          IN_W      = DefInW,
    parameter int unsigned          OUT_W     = DefOutW,
    parameter int unsigned          NUM_VEC   = 1024,
    parameter int unsigned          CNT_W     = 16,
    parameter logic [OUT_W-1:0]     MISR_POLY = OUT_W'(DefMisrPoly)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [IN_W-1:0]  vec_in,
    input  logic [OUT_W-1:0] ref_out,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [IN_W-1:0]  first_fail_vec,
    output logic [OUT_W-1:0] signature
);

    // The run index must reach NUM_VEC-1 even when the reported counters are narrower.
    localparam int unsigned VecBits = int'($clog2(NUM_VEC));
    localparam int unsigned IdxW    = (CNT_W > VecBits) ? CNT_W : VecBits;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VEC - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ffi_q, ffi_d;
    logic [IN_W-1:0]   ffv_q, ffv_d;
    logic              seen_q, seen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              clr;
    logic              accept;
    logic              mismatch;

    assign vec_ready = (state_q == StRun);
    assign accept    = vec_valid && vec_ready;
    assign mismatch  = (ref_out != dut_out);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        seen_d  = seen_q;
        clr     = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    clr     = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ffi_d   = '0;
                    ffv_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    idx_d = idx_q + IdxW'(1);
                    if (mismatch) begin
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        if (!seen_q) begin
                            ffi_d  = CNT_W'(idx_q);
                            ffv_d  = vec_in;
                            seen_d = 1'b1;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Status flags are registered from the next state so they align with the results.
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
        pass_d = done_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    misr_reg #(
        .WIDTH (OUT_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (accept),
        .din (dut_out),
        .sig (signature)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vec = ffv_q;

endmodule
